// File: rtl/cp_pkg.sv
// Shared types, widths and the config legality rule for the CP symbol scheduler.
package cp_pkg;

    localparam int unsigned LEN_W         = 13;
    localparam int unsigned CNT_W         = 14;
    localparam int unsigned SYM_CNT_W     = 16;
    localparam int unsigned MAX_FRAME_DEF = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } cp_state_e;

    typedef struct packed {
        logic [LEN_W-1:0] cp_len;
        logic [LEN_W-1:0] frame_len;
    } cp_cfg_t;

    // Legal: 2 <= frame <= max_frame, 1 <= cp <= frame.
    function automatic logic cfg_is_legal(input cp_cfg_t cfg, input logic [CNT_W-1:0] max_frame);
        logic [CNT_W-1:0] w_frame;
        w_frame = CNT_W'(cfg.frame_len);
        return (cfg.frame_len >= LEN_W'(2)) && (w_frame <= max_frame) &&
               (cfg.cp_len >= LEN_W'(1)) && (cfg.cp_len <= cfg.frame_len);
    endfunction

endpackage

// File: rtl/cp_symbol_scheduler_if.sv
// Config handshake, datapath strobes and status bundle of the CP symbol scheduler.
interface cp_symbol_scheduler_if;
    import cp_pkg::*;

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [LEN_W-1:0]     cfg_cp_len;
    logic [LEN_W-1:0]     cfg_frame_len;
    logic                 enable;
    logic                 dp_in_fire;
    logic                 dp_out_fire;
    logic                 dp_rst;
    logic [LEN_W-1:0]     dp_cp_len;
    logic [LEN_W-1:0]     dp_frame_len;
    logic                 sym_start;
    logic                 sym_done;
    logic                 busy;
    logic                 cfg_err;
    logic                 ovf_err;
    logic [SYM_CNT_W-1:0] sym_count;

    modport master (
        output cfg_valid, cfg_cp_len, cfg_frame_len, enable, dp_in_fire, dp_out_fire,
        input  cfg_ready, dp_rst, dp_cp_len, dp_frame_len, sym_start, sym_done,
               busy, cfg_err, ovf_err, sym_count
    );

    modport slave (
        input  cfg_valid, cfg_cp_len, cfg_frame_len, enable, dp_in_fire, dp_out_fire,
        output cfg_ready, dp_rst, dp_cp_len, dp_frame_len, sym_start, sym_done,
               busy, cfg_err, ovf_err, sym_count
    );

endinterface

// File: rtl/cp_cfg_slot.sv
// One-entry config shadow: accepts when empty, drops illegal configs and flags them.
module cp_cfg_slot
    import cp_pkg::*;
#(
    parameter int unsigned MAX_FRAME = MAX_FRAME_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_valid,
    input  cp_cfg_t i_cfg,
    input  logic    i_load,
    output logic    o_ready,
    output logic    o_full,
    output cp_cfg_t o_cfg,
    output logic    o_err
);

    logic    r_full;
    logic    r_ready;
    logic    r_err;
    cp_cfg_t r_cfg;

    logic    w_accept;
    logic    w_legal;
    logic    w_full_nxt;

    // A load and a fresh legal accept may coincide; the accept wins the slot.
    always_comb begin
        w_accept   = i_valid & r_ready;
        w_legal    = cfg_is_legal(i_cfg, CNT_W'(MAX_FRAME));
        w_full_nxt = r_full & ~i_load;
        if (w_accept && w_legal) begin
            w_full_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full  <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_cfg   <= '0;
        end else begin
            r_full  <= w_full_nxt;
            r_ready <= ~w_full_nxt;
            if (w_accept && w_legal) begin
                r_cfg <= i_cfg;
            end
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_full  = r_full;
    assign o_cfg   = r_cfg;
    assign o_err   = r_err;

endmodule

// File: rtl/cp_symbol_scheduler.sv
// Sequences CP symbols: flushes the datapath, tracks sample counts, and chains queued configs.
module cp_symbol_scheduler
    import cp_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MAX_FRAME    = MAX_FRAME_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cp_symbol_scheduler_if.slave  bus
);

    localparam int unsigned FC_W = 4;

    cp_state_e            r_state;
    logic                 r_dp_rst;
    logic [LEN_W-1:0]     r_cp_len;
    logic [LEN_W-1:0]     r_frame_len;
    logic [CNT_W-1:0]     r_in_cnt;
    logic [CNT_W-1:0]     r_out_cnt;
    logic [FC_W-1:0]      r_fcnt;
    logic                 r_sym_start;
    logic                 r_sym_done;
    logic                 r_busy;
    logic                 r_ovf_err;
    logic [SYM_CNT_W-1:0] r_sym_count;

    cp_cfg_t              w_cfg_in;
    cp_cfg_t              w_slot_cfg;
    logic                 w_slot_full;
    logic                 w_slot_ready;
    logic                 w_slot_err;
    logic [CNT_W-1:0]     w_out_target;
    logic                 w_in_full;
    logic                 w_out_full;
    logic                 w_complete;
    logic                 w_load;
    logic                 w_flush_last;

    assign w_cfg_in.cp_len    = bus.cfg_cp_len;
    assign w_cfg_in.frame_len = bus.cfg_frame_len;

    cp_cfg_slot #(
        .MAX_FRAME (MAX_FRAME)
    ) u_cfg_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (bus.cfg_valid),
        .i_cfg   (w_cfg_in),
        .i_load  (w_load),
        .o_ready (w_slot_ready),
        .o_full  (w_slot_full),
        .o_cfg   (w_slot_cfg),
        .o_err   (w_slot_err)
    );

    // Completion and start decisions; a load happens from IDLE or straight out of a finished symbol.
    always_comb begin
        w_out_target = CNT_W'(r_frame_len) + CNT_W'(r_cp_len);
        w_in_full    = (r_in_cnt == CNT_W'(r_frame_len));
        w_out_full   = (r_out_cnt == w_out_target);
        w_complete   = (r_state == ST_RUN) && w_in_full && w_out_full;
        w_load       = ((r_state == ST_IDLE) || w_complete) && w_slot_full && bus.enable;
        w_flush_last = (r_state == ST_FLUSH) && (r_fcnt == FC_W'(FLUSH_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dp_rst    <= 1'b1;
            r_cp_len    <= '0;
            r_frame_len <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_fcnt      <= '0;
            r_sym_start <= 1'b0;
            r_sym_done  <= 1'b0;
            r_busy      <= 1'b0;
            r_ovf_err   <= 1'b0;
            r_sym_count <= '0;
        end else begin
            r_sym_start <= 1'b0;
            r_sym_done  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                end
                ST_FLUSH: begin
                    if (w_flush_last) begin
                        r_state     <= ST_RUN;
                        r_dp_rst    <= 1'b0;
                        r_sym_start <= 1'b1;
                    end else begin
                        r_fcnt <= r_fcnt + FC_W'(1);
                    end
                end
                ST_RUN: begin
                    // Counters saturate at their targets; any further strobe is an overrun.
                    if (bus.dp_in_fire) begin
                        if (w_in_full) begin
                            r_ovf_err <= 1'b1;
                        end else begin
                            r_in_cnt <= r_in_cnt + CNT_W'(1);
                        end
                    end
                    if (bus.dp_out_fire) begin
                        if (w_out_full) begin
                            r_ovf_err <= 1'b1;
                        end else begin
                            r_out_cnt <= r_out_cnt + CNT_W'(1);
                        end
                    end
                    if (w_complete) begin
                        r_sym_done  <= 1'b1;
                        r_sym_count <= r_sym_count + SYM_CNT_W'(1);
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Entering FLUSH overrides the IDLE fall-through of a completed symbol.
            if (w_load) begin
                r_state     <= ST_FLUSH;
                r_dp_rst    <= 1'b1;
                r_busy      <= 1'b1;
                r_cp_len    <= w_slot_cfg.cp_len;
                r_frame_len <= w_slot_cfg.frame_len;
                r_in_cnt    <= '0;
                r_out_cnt   <= '0;
                r_fcnt      <= '0;
            end
        end
    end

    assign bus.cfg_ready    = w_slot_ready;
    assign bus.cfg_err      = w_slot_err;
    assign bus.dp_rst       = r_dp_rst;
    assign bus.dp_cp_len    = r_cp_len;
    assign bus.dp_frame_len = r_frame_len;
    assign bus.sym_start    = r_sym_start;
    assign bus.sym_done     = r_sym_done;
    assign bus.busy         = r_busy;
    assign bus.ovf_err      = r_ovf_err;
    assign bus.sym_count    = r_sym_count;

endmodule

// File: tb/tb_cp_symbol_scheduler.sv
// Directed + randomized bench for cp_symbol_scheduler against a queue-based symbol model.
module tb_cp_symbol_scheduler;

    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned MAX_FRAME    = 4096;

    typedef struct {
        int cp;
        int fr;
    } cfg_m_t;

    logic clk;
    logic rst_n;

    cp_symbol_scheduler_if bus();

    cp_symbol_scheduler #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .MAX_FRAME    (MAX_FRAME)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: configs waiting to start, live config, expected counters/flags.
    cfg_m_t q[$];
    cfg_m_t live;
    int     exp_count   = 0;
    int     exp_starts  = 0;
    int     exp_dones   = 0;
    logic   exp_cfg_err = 1'b0;
    logic   exp_ovf     = 1'b0;

    // Event monitor sampled mid-cycle.
    int n_start   = 0;
    int n_done    = 0;
    int flush_cyc = 0;
    int flush_mark = 0;

    always @(negedge clk) begin
        if (bus.busy === 1'b1 && bus.dp_rst === 1'b1) flush_cyc++;
        if (bus.sym_start === 1'b1) n_start++;
        if (bus.sym_done === 1'b1) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    function automatic bit legal(input int cp, input int fr);
        return (fr >= 2) && (fr <= int'(MAX_FRAME)) && (cp >= 1) && (cp <= fr);
    endfunction

    task automatic send_cfg(input int cp, input int fr);
        int n = 0;
        cfg_m_t c;
        while (bus.cfg_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("cfg_ready_wait", 32'(bus.cfg_ready), 32'd1);
        bus.cfg_cp_len    = 13'(cp);
        bus.cfg_frame_len = 13'(fr);
        bus.cfg_valid     = 1'b1;
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b0;
        if (legal(cp, fr)) begin
            c.cp = cp;
            c.fr = fr;
            q.push_back(c);
        end else begin
            exp_cfg_err = 1'b1;
        end
    endtask

    task automatic wait_start();
        int n = 0;
        smp();
        while (bus.sym_start !== 1'b1 && n < 64) begin
            smp();
            n++;
        end
        check("start_seen", 32'(bus.sym_start), 32'd1);
        exp_starts++;
        if (q.size() > 0) live = q.pop_front();
        check("start_cp_len", 32'(bus.dp_cp_len), 32'(live.cp));
        check("start_frame_len", 32'(bus.dp_frame_len), 32'(live.fr));
        check("flush_cycles", 32'(flush_cyc - flush_mark), 32'(FLUSH_CYCLES));
        flush_mark = flush_cyc;
        check("run_dp_rst", 32'(bus.dp_rst), 32'd0);
        check("run_busy", 32'(bus.busy), 32'd1);
    endtask

    // Drives the live symbol's strobes at random density; 'extra' adds one in-fire past the frame.
    task automatic fire_symbol(input int p_in, input int p_out, input bit extra);
        int  rem_in  = live.fr;
        int  rem_out = live.fr + live.cp;
        bit  ex      = extra;
        int  guard   = 0;
        bit  fi;
        bit  fo;
        bit  b2b;
        while ((rem_in > 0 || rem_out > 0) && guard < 20000) begin
            fi = (rem_in > 0) && ($urandom_range(99) < p_in);
            if (rem_in == 0 && ex && rem_out > 0) begin
                fi = 1'b1;
                ex = 1'b0;
                exp_ovf = 1'b1;
            end
            fo = (rem_out > 0) && ($urandom_range(99) < p_out);
            bus.dp_in_fire  = fi;
            bus.dp_out_fire = fo;
            @(posedge clk);
            #1;
            if (fi && rem_in > 0) rem_in--;
            if (fo) rem_out--;
            guard++;
        end
        bus.dp_in_fire  = 1'b0;
        bus.dp_out_fire = 1'b0;
        check("fire_budget", 32'(guard < 20000), 32'd1);
        smp();
        check("done_not_early", 32'(bus.sym_done), 32'd0);
        check("busy_in_completion", 32'(bus.busy), 32'd1);
        smp();
        check("done_pulse", 32'(bus.sym_done), 32'd1);
        exp_count = (exp_count + 1) % 65536;
        exp_dones++;
        check("sym_count", 32'(bus.sym_count), 32'(exp_count));
        b2b = (q.size() > 0) && (bus.enable === 1'b1);
        check("busy_after_done", 32'(bus.busy), 32'(b2b));
        if (b2b) begin
            check("b2b_dp_rst", 32'(bus.dp_rst), 32'd1);
            check("b2b_cp_len", 32'(bus.dp_cp_len), 32'(q[0].cp));
            check("b2b_frame_len", 32'(bus.dp_frame_len), 32'(q[0].fr));
        end
        check("cfg_err", 32'(bus.cfg_err), 32'(exp_cfg_err));
        check("ovf_err", 32'(bus.ovf_err), 32'(exp_ovf));
        smp();
        check("done_single", 32'(bus.sym_done), 32'd0);
        check("start_total", 32'(n_start), 32'(exp_starts));
        check("done_total", 32'(n_done), 32'(exp_dones));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_ready"}, 32'(bus.cfg_ready), 32'd0);
        check({tag, "_dp_rst"}, 32'(bus.dp_rst), 32'd1);
        check({tag, "_dp_cp_len"}, 32'(bus.dp_cp_len), 32'd0);
        check({tag, "_dp_frame_len"}, 32'(bus.dp_frame_len), 32'd0);
        check({tag, "_sym_start"}, 32'(bus.sym_start), 32'd0);
        check({tag, "_sym_done"}, 32'(bus.sym_done), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_cfg_err"}, 32'(bus.cfg_err), 32'd0);
        check({tag, "_ovf_err"}, 32'(bus.ovf_err), 32'd0);
        check({tag, "_sym_count"}, 32'(bus.sym_count), 32'd0);
    endtask

    initial begin
        int fr;
        int cp;
        int mark;

        rst_n             = 1'b0;
        bus.cfg_valid     = 1'b0;
        bus.cfg_cp_len    = '0;
        bus.cfg_frame_len = '0;
        bus.enable        = 1'b0;
        bus.dp_in_fire    = 1'b0;
        bus.dp_out_fire   = 1'b0;

        // Reset values, and cfg_ready rising only after the first clock.
        smp();
        smp();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        #1;
        check("ready_before_clk", 32'(bus.cfg_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_clk", 32'(bus.cfg_ready), 32'd1);
        check("idle_dp_rst", 32'(bus.dp_rst), 32'd1);
        bus.enable = 1'b1;

        // Single symbol.
        send_cfg(16, 64);
        wait_start();
        fire_symbol(70, 80, 1'b0);

        // Back-to-back: second config queued during RUN.
        send_cfg(16, 64);
        wait_start();
        send_cfg(8, 32);
        fire_symbol(60, 60, 1'b0);
        wait_start();
        fire_symbol(50, 90, 1'b0);

        // Randomized legal symbols, sometimes chained.
        for (int s = 0; s < 6; s++) begin
            if (q.size() == 0) begin
                fr = int'($urandom_range(48, 2));
                cp = int'($urandom_range(fr, 1));
                send_cfg(cp, fr);
            end
            wait_start();
            if (s < 5 && $urandom_range(1) == 1) begin
                fr = int'($urandom_range(48, 2));
                cp = int'($urandom_range(fr, 1));
                send_cfg(cp, fr);
            end
            fire_symbol(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 1'b0);
        end

        // Boundary legal configs: smallest symbol and largest frame.
        send_cfg(2, 2);
        wait_start();
        fire_symbol(100, 100, 1'b0);
        send_cfg(1, int'(MAX_FRAME));
        wait_start();
        fire_symbol(100, 100, 1'b0);

        // Illegal config: accepted, flagged, nothing starts.
        mark = n_start;
        send_cfg(70, 64);
        repeat (10) smp();
        check("illegal_cfg_err", 32'(bus.cfg_err), 32'(exp_cfg_err));
        check("illegal_busy", 32'(bus.busy), 32'd0);
        check("illegal_no_start", 32'(n_start), 32'(mark));
        check("illegal_ready", 32'(bus.cfg_ready), 32'd1);

        // Overrun: one in-fire beyond the frame; completion timing proves the count held.
        send_cfg(16, 64);
        wait_start();
        fire_symbol(100, 50, 1'b1);

        // Enable dropped mid-RUN with a queued config.
        send_cfg(8, 32);
        wait_start();
        send_cfg(4, 16);
        bus.enable = 1'b0;
        fire_symbol(60, 60, 1'b0);
        mark = n_start;
        repeat (5) smp();
        check("hold_busy", 32'(bus.busy), 32'd0);
        check("hold_ready", 32'(bus.cfg_ready), 32'd0);
        check("hold_no_start", 32'(n_start), 32'(mark));
        bus.enable = 1'b1;
        wait_start();
        fire_symbol(60, 60, 1'b0);

        // Reset in the middle of a symbol at out_cnt = 40.
        send_cfg(16, 64);
        wait_start();
        for (int i = 0; i < 64; i++) begin
            bus.dp_in_fire  = 1'b1;
            bus.dp_out_fire = (i < 40);
            @(posedge clk);
            #1;
        end
        bus.dp_in_fire  = 1'b0;
        bus.dp_out_fire = 1'b0;
        check("mid_run_busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        mark = n_done;
        q.delete();
        exp_count   = 0;
        exp_cfg_err = 1'b0;
        exp_ovf     = 1'b0;
        smp();
        smp();
        rst_n = 1'b1;
        repeat (5) smp();
        check("midrst_no_done", 32'(n_done), 32'(mark));
        check("midrst_sym_count", 32'(bus.sym_count), 32'd0);
        check("midrst_idle_dp_rst", 32'(bus.dp_rst), 32'd1);
        check("midrst_busy", 32'(bus.busy), 32'd0);

        // After reset: cp = 0 is illegal, then a normal symbol recovers.
        mark = n_start;
        send_cfg(0, 64);
        repeat (6) smp();
        check("cp0_cfg_err", 32'(bus.cfg_err), 32'(exp_cfg_err));
        check("cp0_no_start", 32'(n_start), 32'(mark));
        send_cfg(3, 5);
        wait_start();
        fire_symbol(80, 80, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
